mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
Parametrised iterative multiply/divide unit for the MIPS core; executes MULT, MULTU, DIV and DIVU over several cycles and produces a {HI, LO} pair for the HI/LO register file. Sits beside the single-cycle ALU in EX. The pipeline stalls on busy and commits result to HI/LO on done. Supports flush cancellation and defined divide-by-zero and overflow corner cases.

Parameters:
WIDTH, 32, operand width in bits; result is 2*WIDTH; iteration count equals WIDTH
CNT_W, $clog2(WIDTH+1), width of the internal iteration counter (derived, not to be overridden)

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  request; accepted only when ready=1
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
a  input  WIDTH  multiplicand / dividend (rs)
b  input  WIDTH  multiplier / divisor (rt)
cancel  input  1  flush; aborts any operation in progress
ready  output  1  high in IDLE; unit can accept start
busy  output  1  high while an accepted operation is in flight (CALC or DONE state)
done  output  1  one-cycle pulse; result valid from this cycle on
result  output  2*WIDTH  {HI, LO}; MUL: {product_hi, product_lo}; DIV: {remainder, quotient}
div_by_zero  output  1  set with done when a DIV/DIVU had b==0; cleared on the next accepted start

Behaviour:
- Reset (resetn low, async): state=IDLE, result=0, done=0, busy=0, div_by_zero=0, counter=0; ready=1 after reset.
- States: IDLE, CALC, DONE. ready = (state==IDLE); busy = (state!=IDLE).
- IDLE: start=1 and cancel=0 -> latch op, a, b; clear div_by_zero; go CALC (or DONE on divide-by-zero). start while not IDLE is ignored.
- Signed ops (MULT, DIV): operate on magnitudes |a|, |b| held as WIDTH-bit unsigned; record sign_a and sign_b. The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits unsigned.
- MUL in CALC: shift-add, one multiplier bit per cycle, 2*WIDTH accumulator.
- DIV in CALC: restoring division, one quotient bit per cycle, WIDTH+1-bit partial remainder.
- Counter runs 0..WIDTH-1; on count WIDTH-1 go DONE.
- Entering DONE, apply sign correction:
  - MULT: negate the 2*WIDTH product if sign_a^sign_b.
  - DIV: negate the quotient if sign_a^sign_b; the remainder takes sign_a.
  - All arithmetic is modulo 2^WIDTH, so DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0, with no trap.
- result is registered on entry to DONE and held stable until the next accepted start completes.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: start accepted at edge 0 -> done high in cycle WIDTH+1 (33 for WIDTH=32). Back-to-back: the next start is accepted in the cycle after done.
- Divide by zero (DIV/DIVU, b==0): skip CALC, go directly to DONE; done high in cycle 1.
  - result = {a, all-ones}: HI = dividend unchanged, LO = 0xFFFF_FFFF.
  - div_by_zero=1, same for signed and unsigned.
- Multiply by zero takes the full WIDTH iterations; there is no early exit.
- cancel: from any state, go to IDLE on the next edge. done is not pulsed and result and div_by_zero are unchanged.
  - cancel and start in the same IDLE cycle: cancel wins and nothing is accepted.
  - cancel in the DONE cycle: done still shows 1 that cycle (registered); the consumer gates commit with its own flush.
- Reset mid-operation: immediate return to reset values; the in-flight operation is lost.

Test Plan:
- MULT a=0xFFFFFFFF, b=0x00000002 -> done at cycle 33, result=0xFFFFFFFF_FFFFFFFE, busy high cycles 1..33, ready back at cycle 34.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFE_00000001; MULT 0x80000000*0x80000000 -> 0x40000000_00000000.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU 7/2 -> LO=3, HI=1; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=100, b=0 -> done in cycle 1, div_by_zero=1, result=0x00000064_FFFFFFFF; the next accepted start clears div_by_zero.
- Start MULT 3*5, assert cancel at cycle 10 -> no done pulse, ready=1 at cycle 11, result holds its previous value. Then start MULTU 3*5 -> result=0x00000000_0000000F at cycle 33.
- Pull resetn low mid-DIV at cycle 5 -> outputs zero immediately and ready=1. start held high while busy -> ignored, and the operands of the first op are still used.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit for the MIPS EX stage.
// Executes MULT, MULTU, DIV and DIVU and delivers a {HI, LO} pair.
// Multiplication uses shift-add, one multiplier bit per cycle.
// Division uses restoring division, one quotient bit per cycle.
// Signed operations run on operand magnitudes. The sign is fixed up
// when the result is captured on entry to DONE.
module mul_div_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cancel,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 is_div_r;
    logic                 sign_a_r;
    logic                 sign_b_r;
    logic [WIDTH-1:0]     mag_a_r;
    logic [WIDTH-1:0]     mag_b_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH:0]       rem_r;
    logic [WIDTH-1:0]     quo_r;
    logic [2*WIDTH-1:0]   result_r;
    logic                 done_r;
    logic                 dbz_r;
    logic                 ready_r;
    logic                 busy_r;

    logic                 op_signed_s;
    logic                 sign_a_s;
    logic                 sign_b_s;
    logic [WIDTH-1:0]     mag_a_s;
    logic [WIDTH-1:0]     mag_b_s;
    logic [WIDTH:0]       hi_sum_s;
    logic [2*WIDTH-1:0]   mul_next_s;
    logic [WIDTH:0]       shift_s;
    logic [WIDTH:0]       diff_s;
    logic [WIDTH:0]       rem_next_s;
    logic [WIDTH-1:0]     quo_next_s;
    logic [2*WIDTH-1:0]   mul_fix_s;
    logic [WIDTH-1:0]     quo_fix_s;
    logic [WIDTH-1:0]     rem_fix_s;
    logic [2*WIDTH-1:0]   final_s;
    logic                 last_step_s;

    // Decode the incoming operands into sign flags and unsigned magnitudes
    always_comb begin
        op_signed_s = ~op[0];
        sign_a_s    = op_signed_s & a[WIDTH-1];
        sign_b_s    = op_signed_s & b[WIDTH-1];
        if (sign_a_s) begin
            mag_a_s = {WIDTH{1'b0}} - a;
        end else begin
            mag_a_s = a;
        end
        if (sign_b_s) begin
            mag_b_s = {WIDTH{1'b0}} - b;
        end else begin
            mag_b_s = b;
        end
    end

    // One iteration step for each algorithm, plus sign-corrected final result
    always_comb begin
        if (acc_r[0]) begin
            hi_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mag_a_r};
        end else begin
            hi_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        mul_next_s = {hi_sum_s, acc_r[WIDTH-1:1]};

        shift_s = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
        diff_s  = shift_s - {1'b0, mag_b_r};
        if (diff_s[WIDTH]) begin
            rem_next_s = shift_s;
            quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
        end else begin
            rem_next_s = diff_s;
            quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
        end

        if (sign_a_r ^ sign_b_r) begin
            mul_fix_s = {(2*WIDTH){1'b0}} - mul_next_s;
            quo_fix_s = {WIDTH{1'b0}} - quo_next_s;
        end else begin
            mul_fix_s = mul_next_s;
            quo_fix_s = quo_next_s;
        end
        // The remainder follows the sign of the dividend
        if (sign_a_r) begin
            rem_fix_s = {WIDTH{1'b0}} - rem_next_s[WIDTH-1:0];
        end else begin
            rem_fix_s = rem_next_s[WIDTH-1:0];
        end

        if (is_div_r) begin
            final_s = {rem_fix_s, quo_fix_s};
        end else begin
            final_s = mul_fix_s;
        end
        last_step_s = (cnt_r == CNT_W'(WIDTH - 1));
    end

    // Control FSM with datapath registers and registered handshake outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r  <= S_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            is_div_r <= 1'b0;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            mag_a_r  <= {WIDTH{1'b0}};
            mag_b_r  <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            rem_r    <= {(WIDTH+1){1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            result_r <= {(2*WIDTH){1'b0}};
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
        end else if (cancel) begin
            // Flush: abandon the operation and keep result/div_by_zero intact
            state_r <= S_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            done_r  <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        is_div_r <= op[1];
                        sign_a_r <= sign_a_s;
                        sign_b_r <= sign_b_s;
                        mag_a_r  <= mag_a_s;
                        mag_b_r  <= mag_b_s;
                        acc_r    <= {{WIDTH{1'b0}}, mag_b_s};
                        rem_r    <= {(WIDTH+1){1'b0}};
                        quo_r    <= mag_a_s;
                        cnt_r    <= {CNT_W{1'b0}};
                        ready_r  <= 1'b0;
                        busy_r   <= 1'b1;
                        if (op[1] && (b == {WIDTH{1'b0}})) begin
                            // Divide by zero: dividend to HI, all-ones to LO
                            result_r <= {a, {WIDTH{1'b1}}};
                            dbz_r    <= 1'b1;
                            done_r   <= 1'b1;
                            state_r  <= S_DONE;
                        end else begin
                            dbz_r   <= 1'b0;
                            state_r <= S_CALC;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (is_div_r) begin
                        rem_r <= rem_next_s;
                        quo_r <= quo_next_s;
                    end else begin
                        acc_r <= mul_next_s;
                    end
                    if (last_step_s) begin
                        result_r <= final_s;
                        done_r   <= 1'b1;
                        cnt_r    <= {CNT_W{1'b0}};
                        state_r  <= S_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign ready       = ready_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign result      = result_r;
    assign div_by_zero = dbz_r;

endmodule
